// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and widths for the 4:1 mux scan controller.
package mux_scan_ctrl_pkg;

  localparam int DWELL_W = 8;
  localparam int FRAME_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] ch;
  } ch_pick_t;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Scan controller: steps mux selects over enabled channels, samples mux_o after
// DWELL cycles per channel and hands one 4-bit frame downstream via valid/ready.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               continuous,
  input  logic [FRAME_W-1:0] ch_mask,
  input  logic               mux_o,
  output logic               s0,
  output logic               s1,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               busy
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  state_t             state_r;
  logic [1:0]         ch_r;
  logic [DWELL_W-1:0] dwell_cnt_r;
  logic [FRAME_W-1:0] mask_r;
  ch_pick_t           first_s;
  ch_pick_t           next_s;
  logic               launch_s;

  // Lowest enabled channel whose index is >= from; found=0 when none is left.
  function automatic ch_pick_t pick_from(input logic [FRAME_W-1:0] mask,
                                         input logic [2:0]         from);
    ch_pick_t res;
    res = '0;
    for (int i = FRAME_W - 1; i >= 0; i--) begin
      if ((i >= int'(from)) && mask[i]) begin
        res.found = 1'b1;
        res.ch    = 2'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Channel lookups and the scan-launch condition (start from IDLE or auto-restart).
  always_comb begin
    first_s  = pick_from(ch_mask, 3'd0);
    next_s   = pick_from(mask_r, {1'b0, ch_r} + 3'd1);
    launch_s = 1'b0;
    case (state_r)
      ST_IDLE: launch_s = start;
      ST_HOLD: launch_s = frame_ready & continuous;
      default: launch_s = 1'b0;
    endcase
  end

  // Scan FSM with registered selects, frame, handshake and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ch_r        <= 2'd0;
      dwell_cnt_r <= '0;
      mask_r      <= '0;
      s0          <= 1'b0;
      s1          <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else if (launch_s) begin
      mask_r      <= ch_mask;
      frame       <= '0;
      dwell_cnt_r <= '0;
      busy        <= 1'b1;
      if (first_s.found) begin
        state_r     <= ST_SETTLE;
        ch_r        <= first_s.ch;
        {s0, s1}    <= first_s.ch;
        frame_valid <= 1'b0;
      end else begin
        // Empty mask: nothing to sample, the all-zero frame is ready at once.
        state_r     <= ST_HOLD;
        ch_r        <= 2'd0;
        {s0, s1}    <= 2'b00;
        frame_valid <= 1'b1;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          {s0, s1}    <= 2'b00;
          frame_valid <= 1'b0;
          busy        <= 1'b0;
        end
        ST_SETTLE: begin
          if (dwell_cnt_r == DWELL_LAST) begin
            frame[ch_r] <= mux_o;
            dwell_cnt_r <= '0;
            if (next_s.found) begin
              ch_r     <= next_s.ch;
              {s0, s1} <= next_s.ch;
            end else begin
              state_r     <= ST_HOLD;
              frame_valid <= 1'b1;
            end
          end else begin
            dwell_cnt_r <= dwell_cnt_r + DWELL_W'(1);
          end
        end
        ST_HOLD: begin
          if (frame_ready) begin
            state_r     <= ST_IDLE;
            frame_valid <= 1'b0;
            {s0, s1}    <= 2'b00;
            busy        <= 1'b0;
          end else begin
            frame_valid <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          ch_r        <= 2'd0;
          dwell_cnt_r <= '0;
          {s0, s1}    <= 2'b00;
          frame       <= '0;
          frame_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench: three controllers (DWELL=1,2,3) each driving a modelled 4:1 mux.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start, continuous, frame_ready, mux_o, s0, s1, frame_valid, busy;
  logic [3:0] ch_mask [3];
  logic [3:0] frame   [3];
  logic [3:0] mux_in  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mux_o[0] = mux_in[0][{s0[0], s1[0]}];
  assign mux_o[1] = mux_in[1][{s0[1], s1[1]}];
  assign mux_o[2] = mux_in[2][{s0[2], s1[2]}];

  mux_scan_ctrl #(.DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start[0]), .continuous(continuous[0]),
    .ch_mask(ch_mask[0]), .mux_o(mux_o[0]), .s0(s0[0]), .s1(s1[0]),
    .frame(frame[0]), .frame_valid(frame_valid[0]),
    .frame_ready(frame_ready[0]), .busy(busy[0]));

  mux_scan_ctrl #(.DWELL(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start[1]), .continuous(continuous[1]),
    .ch_mask(ch_mask[1]), .mux_o(mux_o[1]), .s0(s0[1]), .s1(s1[1]),
    .frame(frame[1]), .frame_valid(frame_valid[1]),
    .frame_ready(frame_ready[1]), .busy(busy[1]));

  mux_scan_ctrl #(.DWELL(3)) u_d3 (
    .clk(clk), .rst(rst), .start(start[2]), .continuous(continuous[2]),
    .ch_mask(ch_mask[2]), .mux_o(mux_o[2]), .s0(s0[2]), .s1(s1[2]),
    .frame(frame[2]), .frame_valid(frame_valid[2]),
    .frame_ready(frame_ready[2]), .busy(busy[2]));

  task automatic check(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One non-continuous scan checked against the select schedule implied by mask/dwell.
  task automatic run_scan(input int k, input int dwell, input logic [3:0] mask,
                          input logic [3:0] ins, input int hold_cycles);
    int         sched[$];
    logic [3:0] exp_frame;
    logic [1:0] last_ch;
    last_ch = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        for (int d = 0; d < dwell; d++) sched.push_back(c);
        last_ch = 2'(c);
      end
    end
    exp_frame    = mask & ins;
    mux_in[k]    = ins;
    ch_mask[k]   = mask;
    start[k]     = 1'b1;
    step();
    start[k]     = 1'b0;
    ch_mask[k]   = 4'($urandom);
    foreach (sched[i]) begin
      check("settle_sel", k, 32'({s0[k], s1[k]}), 32'(sched[i]));
      check("settle_valid", k, 32'(frame_valid[k]), 32'd0);
      check("settle_busy", k, 32'(busy[k]), 32'd1);
      step();
    end
    check("done_valid", k, 32'(frame_valid[k]), 32'd1);
    check("done_frame", k, 32'(frame[k]), 32'(exp_frame));
    check("hold_sel", k, 32'({s0[k], s1[k]}), 32'(last_ch));
    for (int w = 0; w < hold_cycles; w++) begin
      start[k]  = 1'b1;
      mux_in[k] = 4'($urandom);
      step();
      check("hold_valid", k, 32'(frame_valid[k]), 32'd1);
      check("hold_frame", k, 32'(frame[k]), 32'(exp_frame));
      check("hold_busy", k, 32'(busy[k]), 32'd1);
    end
    start[k]       = 1'b0;
    frame_ready[k] = 1'b1;
    step();
    frame_ready[k] = 1'b0;
    check("accept_valid", k, 32'(frame_valid[k]), 32'd0);
    check("accept_busy", k, 32'(busy[k]), 32'd0);
    check("accept_sel", k, 32'({s0[k], s1[k]}), 32'd0);
    frame_ready[k] = 1'b1;
    step();
    frame_ready[k] = 1'b0;
    check("idle_valid", k, 32'(frame_valid[k]), 32'd0);
  endtask

  initial begin
    logic [3:0] ins;
    rst         = 1'b1;
    start       = 3'b000;
    continuous  = 3'b000;
    frame_ready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      ch_mask[k] = 4'd0;
      mux_in[k]  = 4'd0;
    end
    repeat (2) step();
    for (int k = 0; k < 3; k++) begin
      check("rst_sel", k, 32'({s0[k], s1[k]}), 32'd0);
      check("rst_frame", k, 32'(frame[k]), 32'd0);
      check("rst_valid", k, 32'(frame_valid[k]), 32'd0);
      check("rst_busy", k, 32'(busy[k]), 32'd0);
    end
    rst = 1'b0;
    step();

    run_scan(0, 1, 4'b1111, 4'b1101, 3);
    run_scan(2, 3, 4'b1010, 4'b1111, 2);
    run_scan(0, 1, 4'b0000, 4'b1111, 3);
    run_scan(1, 2, 4'b0110, 4'b1001, 10);

    // Continuous mode, DWELL=2, ready tied high: 8 settle cycles then 1 hold cycle per frame.
    ins            = 4'b0110;
    mux_in[1]      = ins;
    ch_mask[1]     = 4'b1111;
    continuous[1]  = 1'b1;
    frame_ready[1] = 1'b1;
    start[1]       = 1'b1;
    step();
    start[1] = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 8; c++) begin
        check("cont_sel", 1, 32'({s0[1], s1[1]}), 32'(c / 2));
        check("cont_valid_low", 1, 32'(frame_valid[1]), 32'd0);
        step();
      end
      check("cont_valid", 1, 32'(frame_valid[1]), 32'd1);
      check("cont_frame", 1, 32'(frame[1]), 32'(ins));
      ins       = ~ins ^ 4'(f);
      mux_in[1] = ins;
      if (f == 2) continuous[1] = 1'b0;
      step();
    end
    frame_ready[1] = 1'b0;
    check("cont_end_busy", 1, 32'(busy[1]), 32'd0);
    check("cont_end_valid", 1, 32'(frame_valid[1]), 32'd0);

    // Reset three cycles into a DWELL=2 scan: outputs clear without a clock edge.
    mux_in[1]  = 4'b1111;
    ch_mask[1] = 4'b1111;
    start[1]   = 1'b1;
    step();
    start[1] = 1'b0;
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_sel", 1, 32'({s0[1], s1[1]}), 32'd0);
    check("arst_frame", 1, 32'(frame[1]), 32'd0);
    check("arst_valid", 1, 32'(frame_valid[1]), 32'd0);
    check("arst_busy", 1, 32'(busy[1]), 32'd0);
    step();
    rst = 1'b0;
    repeat (6) step();
    check("post_rst_valid", 1, 32'(frame_valid[1]), 32'd0);
    check("post_rst_busy", 1, 32'(busy[1]), 32'd0);

    for (int r = 0; r < 12; r++) begin
      int k;
      k = $urandom_range(0, 2);
      run_scan(k, k + 1, 4'($urandom), 4'($urandom), $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
